// File: rtl/pipe_pal_arb_pkg.sv
// Shared definitions for the pipe_pal arbiter: FSM encoding, width helper,
// and the round-robin selection used at every grant.
package pipe_pal_arb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Minimum of 1 so single-entry structures still get a real register.
  function automatic int clog2(input int v);
    clog2 = 1;
    for (int i = 1; i < 31; i++) begin
      if ((longint'(1) << i) < longint'(v)) clog2 = i + 1;
    end
  endfunction

  // First set bit of req[n-1:0] after position last, wrapping; returns last when req is empty.
  function automatic int rr_pick(input logic [31:0] req, input int last, input int n);
    int idx;
    rr_pick = last;
    for (int i = 32; i >= 1; i--) begin
      if (i <= n) begin
        idx = last + i;
        if (idx >= n) idx = idx - n;
        if (req[idx[4:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/pipe_pal_id_fifo.sv
// Source-ID FIFO: records which requester issued each beat, read in issue order.
// Registered head, combinational flags; push while full is accepted only with a same-cycle pop.
module pipe_pal_id_fifo
  import pipe_pal_arb_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         resetn,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (do_pop)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/pipe_pal_arbiter.sv
// Round-robin, burst-locked arbiter in front of one pipe_pal datapath, credit-capped at MAX_OUT.
// One bubble per grant, then combinational pass-through; stalls on pipe backpressure or zero credit.
module pipe_pal_arbiter
  import pipe_pal_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int W_DATA    = 32,
  parameter  int BURST_MAX = 8,
  parameter  int MAX_OUT   = 4,
  localparam int W_ID      = clog2(N_REQ),
  localparam int W_OUT     = clog2(MAX_OUT + 1)
) (
  input  logic                      i_clk,
  input  logic                      resetn,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ*W_DATA-1:0]   i_req_data,
  input  logic [N_REQ-1:0]          i_req_last,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic                      o_pipe_valid,
  output logic [W_DATA-1:0]         o_pipe_data,
  output logic [W_ID-1:0]           o_pipe_src,
  input  logic                      i_pipe_ready,
  input  logic                      i_rsp_valid,
  input  logic [W_DATA-1:0]         i_rsp_data,
  output logic [N_REQ-1:0]          o_rsp_valid,
  output logic [W_DATA-1:0]         o_rsp_data,
  output logic [W_OUT-1:0]          o_outstanding,
  output logic                      o_err
);
  localparam int W_BEAT = clog2(BURST_MAX + 1);

  logic [0:0]        state_q, state_d;
  logic [W_ID-1:0]   grant_q, grant_d, last_q, last_d;
  logic [W_BEAT-1:0] beat_q, beat_d;
  logic [W_OUT-1:0]  out_q, out_d;
  logic              err_q, err_d;
  logic              in_burst, credit_ok, accept, burst_end, rsp_pop;
  logic              fifo_full, fifo_empty;
  logic [W_ID-1:0]   fifo_head;

  assign in_burst  = (state_q == ST_BURST);
  // Credit test uses the registered count, so a response frees a slot only next cycle.
  assign credit_ok = (out_q < W_OUT'(MAX_OUT));
  assign accept    = o_pipe_valid && i_pipe_ready;
  assign burst_end = accept && (i_req_last[grant_q] || (beat_q == W_BEAT'(BURST_MAX - 1)));
  assign rsp_pop   = i_rsp_valid && !fifo_empty;

  assign o_pipe_valid  = in_burst && i_req_valid[grant_q] && credit_ok;
  assign o_pipe_data   = in_burst ? i_req_data[int'(grant_q)*W_DATA +: W_DATA] : '0;
  assign o_pipe_src    = grant_q;
  assign o_rsp_valid   = rsp_pop ? (N_REQ'(1) << fifo_head) : '0;
  assign o_rsp_data    = i_rsp_valid ? i_rsp_data : '0;
  assign o_outstanding = out_q;
  assign o_err         = err_q;

  always_comb begin
    o_req_ready = '0;
    if (in_burst && i_pipe_ready && credit_ok) o_req_ready[grant_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (|i_req_valid) begin
          grant_d = W_ID'(rr_pick(32'(i_req_valid), int'(last_q), N_REQ));
          beat_d  = '0;
          state_d = ST_BURST;
        end
      end
      default: begin
        // A requester that drops valid mid-burst keeps the lock indefinitely.
        if (accept) begin
          beat_d = beat_q + 1'b1;
          if (burst_end) begin
            state_d = ST_IDLE;
            last_d  = grant_q;
          end
        end
      end
    endcase
  end

  always_comb begin
    case ({accept, rsp_pop})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
    err_d = err_q || (i_rsp_valid && fifo_empty);
  end

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= W_ID'(N_REQ - 1);
      beat_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  pipe_pal_id_fifo #(
    .W     (W_ID),
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .i_clk   (i_clk),
    .resetn  (resetn),
    .push_i  (accept && (!fifo_full || rsp_pop)),
    .din_i   (grant_q),
    .pop_i   (rsp_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_pipe_pal_arbiter.sv
// Bench for pipe_pal_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed grant orders, timings and routes.
module tb_pipe_pal_arbiter;
  localparam int N_REQ     = 4;
  localparam int W_DATA    = 32;
  localparam int BURST_MAX = 8;
  localparam int MAX_OUT   = 4;
  localparam int W_ID      = 2;
  localparam int W_OUT     = 3;

  logic                    i_clk = 1'b0;
  logic                    resetn = 1'b0;
  logic [N_REQ-1:0]        i_req_valid = '0;
  logic [N_REQ*W_DATA-1:0] i_req_data = '0;
  logic [N_REQ-1:0]        i_req_last = '0;
  logic [N_REQ-1:0]        o_req_ready;
  logic                    o_pipe_valid;
  logic [W_DATA-1:0]       o_pipe_data;
  logic [W_ID-1:0]         o_pipe_src;
  logic                    i_pipe_ready = 1'b0;
  logic                    i_rsp_valid = 1'b0;
  logic [W_DATA-1:0]       i_rsp_data = '0;
  logic [N_REQ-1:0]        o_rsp_valid;
  logic [W_DATA-1:0]       o_rsp_data;
  logic [W_OUT-1:0]        o_outstanding;
  logic                    o_err;

  pipe_pal_arbiter #(
    .N_REQ(N_REQ), .W_DATA(W_DATA), .BURST_MAX(BURST_MAX), .MAX_OUT(MAX_OUT)
  ) dut (
    .i_clk(i_clk), .resetn(resetn),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .i_req_last(i_req_last),
    .o_req_ready(o_req_ready),
    .o_pipe_valid(o_pipe_valid), .o_pipe_data(o_pipe_data), .o_pipe_src(o_pipe_src),
    .i_pipe_ready(i_pipe_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_outstanding(o_outstanding), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Requester traffic generators
  int rem[N_REQ], blen[N_REQ], bidx[N_REQ], seq[N_REQ];
  int rsp_delay = -1;
  bit rsp_force = 1'b0;
  int due[$];
  logic [N_REQ-1:0] fired = '0;

  // Observation logs
  int acc_log[$], acc_cyc[$], rsp_log[$];

  // Reference model state
  bit m_busy;
  int m_gnt, m_last, m_beats;
  bit m_err;
  int m_idq[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic bit vbit(input logic [N_REQ-1:0] v, input int c);
    logic [N_REQ-1:0] t;
    t = v >> c;
    return t[0];
  endfunction

  function automatic logic [W_DATA-1:0] slice(input int c);
    logic [N_REQ*W_DATA-1:0] t;
    t = i_req_data >> (c * W_DATA);
    return t[W_DATA-1:0];
  endfunction

  task automatic drive();
    logic [N_REQ-1:0]        v, l;
    logic [N_REQ*W_DATA-1:0] d;
    v = '0; l = '0; d = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (rem[k] > 0) begin
        v |= N_REQ'(1) << k;
        if (bidx[k] == blen[k] - 1 || rem[k] == 1) l |= N_REQ'(1) << k;
      end
      d |= (N_REQ*W_DATA)'({8'(k), 24'(seq[k])}) << (k * W_DATA);
    end
    i_req_valid = v;
    i_req_last  = l;
    i_req_data  = d;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    cyc++;
    for (int k = 0; k < N_REQ; k++) begin
      if (vbit(fired, k)) begin
        rem[k]--;
        seq[k]++;
        bidx[k] = (bidx[k] == blen[k] - 1) ? 0 : bidx[k] + 1;
      end
    end
    fired = '0;
    i_rsp_valid = 1'b0;
    if (rsp_force) begin
      i_rsp_valid = 1'b1;
      rsp_force = 1'b0;
    end else if (due.size() > 0 && due[0] <= cyc) begin
      i_rsp_valid = 1'b1;
      void'(due.pop_front());
    end
    i_rsp_data = 32'hA500_0000 + 32'(cyc);
    drive();
  endtask

  task automatic settle();
    @(negedge i_clk);
    #1;
  endtask

  task automatic clear_traffic();
    for (int k = 0; k < N_REQ; k++) begin
      rem[k] = 0; blen[k] = 1; bidx[k] = 0; seq[k] = 0;
    end
    due.delete();
    rsp_force = 1'b0;
    rsp_delay = -1;
    i_rsp_valid = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_traffic();
    step();
    step();
    resetn = 1'b1;
    acc_log.delete(); acc_cyc.delete(); rsp_log.delete();
  endtask

  // Model: outstanding is simply the number of IDs still waiting for a response.
  always @(negedge i_clk) begin
    logic [N_REQ-1:0] e_rdy, e_rv;
    bit e_pv, can, acc, pop, stray;
    if (!resetn) begin
      m_busy = 0; m_gnt = 0; m_last = N_REQ - 1; m_beats = 0; m_err = 0;
      m_idq.delete();
      fired = '0;
      chk("rst_pipe_valid", o_pipe_valid, 0);
      chk("rst_req_ready", o_req_ready, 0);
      chk("rst_rsp_valid", o_rsp_valid, 0);
      chk("rst_outstanding", o_outstanding, 0);
      chk("rst_err", o_err, 0);
      chk("rst_src", o_pipe_src, 0);
    end else begin
      can   = m_idq.size() < MAX_OUT;
      e_pv  = m_busy && vbit(i_req_valid, m_gnt) && can;
      e_rdy = (m_busy && i_pipe_ready && can) ? (N_REQ'(1) << m_gnt) : '0;
      pop   = i_rsp_valid && m_idq.size() > 0;
      stray = i_rsp_valid && m_idq.size() == 0;
      e_rv  = pop ? (N_REQ'(1) << m_idq[0]) : '0;
      chk("pipe_valid", o_pipe_valid, e_pv);
      chk("req_ready", o_req_ready, e_rdy);
      chk("rsp_valid", o_rsp_valid, e_rv);
      chk("outstanding", o_outstanding, m_idq.size());
      chk("err", o_err, m_err);
      if (e_pv) begin
        chk("pipe_src", o_pipe_src, m_gnt);
        chk("pipe_data", o_pipe_data, slice(m_gnt));
      end
      if (pop) chk("rsp_data", o_rsp_data, i_rsp_data);
      fired = o_req_ready & i_req_valid;
      acc = e_pv && i_pipe_ready;
      if (pop) begin
        rsp_log.push_back(int'(e_rv));
        void'(m_idq.pop_front());
      end
      if (stray) m_err = 1;
      if (acc) begin
        m_idq.push_back(m_gnt);
        acc_log.push_back(m_gnt);
        acc_cyc.push_back(cyc);
        if (rsp_delay >= 0) due.push_back(cyc + rsp_delay);
      end
      if (!m_busy) begin
        for (int i = 1; i <= N_REQ; i++) begin
          if (vbit(i_req_valid, (m_last + i) % N_REQ)) begin
            m_gnt = (m_last + i) % N_REQ;
            m_busy = 1;
            m_beats = 0;
            break;
          end
        end
      end else if (acc) begin
        m_beats++;
        if (vbit(i_req_last, m_gnt) || m_beats == BURST_MAX) begin
          m_busy = 0;
          m_last = m_gnt;
        end
      end
    end
  end

  initial begin
    int c0;
    clear_traffic();
    #1;
    chk("t0_pipe_valid", o_pipe_valid, 0);
    chk("t0_outstanding", o_outstanding, 0);
    chk("t0_err", o_err, 0);

    // Single requester, 3-beat burst
    do_reset();
    i_pipe_ready = 1'b1;
    rsp_delay = 2;
    blen[2] = 3; rem[2] = 3;
    c0 = cyc + 1;
    repeat (10) step();
    settle();
    chk("s1_n_acc", acc_log.size(), 3);
    for (int i = 0; i < 3; i++) chk("s1_src", qget(acc_log, i), 2);
    chk("s1_first_latency", qget(acc_cyc, 0) - c0, 1);
    chk("s1_back_to_back", qget(acc_cyc, 2) - qget(acc_cyc, 0), 2);
    chk("s1_n_rsp", rsp_log.size(), 3);
    for (int i = 0; i < 3; i++) chk("s1_rsp_onehot", qget(rsp_log, i), 4);
    chk("s1_idle_again", o_pipe_valid, 0);

    // Four continuous requesters, 1-beat bursts
    do_reset();
    rsp_delay = 1;
    for (int k = 0; k < N_REQ; k++) begin blen[k] = 1; rem[k] = 4; end
    repeat (40) step();
    settle();
    chk("s2_n_acc", acc_log.size(), 16);
    for (int i = 0; i < 8; i++) chk("s2_rotation", qget(acc_log, i), i % 4);
    for (int i = 0; i < 15; i++) chk("s2_gap", qget(acc_cyc, i + 1) - qget(acc_cyc, i), 2);

    // Burst cap at BURST_MAX beats
    do_reset();
    rsp_delay = 1;
    blen[1] = 12; rem[1] = 12;
    c0 = cyc + 1;
    repeat (20) step();
    settle();
    chk("s3_n_acc", acc_log.size(), 12);
    for (int i = 0; i < 12; i++) chk("s3_src", qget(acc_log, i), 1);
    chk("s3_first_latency", qget(acc_cyc, 0) - c0, 1);
    chk("s3_first_8", qget(acc_cyc, 7) - qget(acc_cyc, 0), 7);
    chk("s3_rearb_bubble", qget(acc_cyc, 8) - qget(acc_cyc, 7), 2);
    chk("s3_tail_4", qget(acc_cyc, 11) - qget(acc_cyc, 8), 3);

    // Credit stall
    do_reset();
    blen[0] = 10; rem[0] = 10;
    repeat (8) step();
    settle();
    chk("s4_acc_at_cap", acc_log.size(), 4);
    chk("s4_out_at_cap", o_outstanding, 4);
    chk("s4_ready_stalled", o_req_ready, 0);
    rsp_force = 1'b1;
    step(); settle();
    chk("s4_rsp_cycle_ready", o_req_ready, 0);
    chk("s4_rsp_cycle_out", o_outstanding, 4);
    step(); settle();
    chk("s4_freed_out", o_outstanding, 3);
    chk("s4_freed_ready", o_req_ready, 1);
    chk("s4_freed_acc", acc_log.size(), 5);
    rsp_force = 1'b1;
    step(); settle();
    chk("s4_refilled_out", o_outstanding, 4);
    rsp_force = 1'b1;
    step(); settle();
    chk("s4_both_out", o_outstanding, 3);
    chk("s4_both_acc", acc_log.size(), 6);
    step(); settle();
    chk("s4_both_unchanged", o_outstanding, 3);

    // Response routing with 5-cycle latency
    do_reset();
    rsp_delay = 5;
    blen[0] = 2; rem[0] = 2;
    blen[3] = 1; rem[3] = 1;
    repeat (14) step();
    settle();
    chk("s5_n_acc", acc_log.size(), 3);
    chk("s5_acc0", qget(acc_log, 0), 0);
    chk("s5_acc1", qget(acc_log, 1), 0);
    chk("s5_acc2", qget(acc_log, 2), 3);
    chk("s5_n_rsp", rsp_log.size(), 3);
    chk("s5_rsp0", qget(rsp_log, 0), 1);
    chk("s5_rsp1", qget(rsp_log, 1), 1);
    chk("s5_rsp2", qget(rsp_log, 2), 8);

    // Stray response, then reset mid-burst
    do_reset();
    rsp_force = 1'b1;
    step(); settle();
    chk("s6_stray_no_route", o_rsp_valid, 0);
    step(); settle();
    chk("s6_err_set", o_err, 1);
    chk("s6_no_underflow", o_outstanding, 0);
    repeat (3) step();
    settle();
    chk("s6_err_sticky", o_err, 1);
    blen[2] = 5; rem[2] = 5;
    repeat (3) step();
    chk("s6_mid_burst", o_pipe_valid, 1);
    resetn = 1'b0;
    #1;
    chk("s6_rst_pipe_valid", o_pipe_valid, 0);
    chk("s6_rst_ready", o_req_ready, 0);
    chk("s6_rst_out", o_outstanding, 0);
    chk("s6_rst_err", o_err, 0);
    chk("s6_rst_src", o_pipe_src, 0);
    clear_traffic();
    step();
    step();
    resetn = 1'b1;
    acc_log.delete(); acc_cyc.delete(); rsp_log.delete();
    blen[0] = 1; rem[0] = 1;
    blen[2] = 1; rem[2] = 1;
    rsp_force = 1'b1;
    repeat (6) step();
    settle();
    chk("s6_post_n_acc", acc_log.size(), 2);
    chk("s6_post_first", qget(acc_log, 0), 0);
    chk("s6_post_second", qget(acc_log, 1), 2);
    chk("s6_post_rsp_none", rsp_log.size(), 0);
    chk("s6_post_err", o_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
